// File: rtl/trg_out_ctrl_gen.sv
// Trigger-output controller: merges trigger sources into accepted triggers, drives the
// active-low FEE trigger bus and check strobe, counts accepted/lost triggers.
// Optional build macro TRG_PRESCALE_EN enables the cycled-source prescaler.
module trg_out_ctrl_gen #(
    parameter int N_SRC           = 3,
    parameter int N_BUSY          = 3,
    parameter int N_OUT           = 14,
    parameter int TRG_PULSE_WIDTH = 20,
    parameter int CHK_PULSE_WIDTH = 50,
    parameter int DT_W            = 8,
    parameter int CNT_W           = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [N_SRC-1:0]   trg_src_in,
    input  logic [N_SRC-1:0]   src_enb_in,
    input  logic               trg_enb_in,
    input  logic [N_BUSY-1:0]  busy_in,
    input  logic [N_BUSY-1:0]  busy_mask_in,
    input  logic               busy_ignore_in,
    input  logic [DT_W-1:0]    trg_dead_time_in,
    input  logic [N_OUT-1:0]   out_enb_in,
    input  logic [CNT_W-1:0]   prescale_in,
    input  logic               cnt_clr_in,
    output logic [N_OUT-1:0]   trg_out_N,
    output logic               chk_out,
    output logic               eff_trg_out,
    output logic [N_SRC-1:0]   trg_type_out,
    output logic [CNT_W-1:0]   eff_trg_cnt_out,
    output logic [CNT_W-1:0]   lost_trg_cnt_out,
    output logic               daq_busy_out
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TRG  = 2'd1;
    localparam logic [1:0] CHK  = 2'd2;
    localparam logic [1:0] DEAD = 2'd3;

    localparam int P_MAX = (TRG_PULSE_WIDTH > CHK_PULSE_WIDTH) ? TRG_PULSE_WIDTH : CHK_PULSE_WIDTH;
    localparam int T_MAX = (P_MAX > (1 << DT_W)) ? P_MAX : (1 << DT_W);
    localparam int TW    = $clog2(T_MAX + 1);

    logic [1:0]       state;
    logic [TW-1:0]    tmr;
    logic [N_SRC-1:0] src_d;
    logic [N_SRC-1:0] edge_raw;
    logic [N_SRC-1:0] edge_vec;
    logic             qbusy;
    logic             fire;
    logic             ready;
    logic             accept;
    logic             lost;

    assign edge_raw = trg_src_in & ~src_d & src_enb_in;

`ifdef TRG_PRESCALE_EN
    logic [CNT_W-1:0] presc_cnt;
    logic [CNT_W-1:0] presc_d;
    logic             presc_pass;

    assign presc_pass = (prescale_in <= CNT_W'(1)) || (presc_cnt == prescale_in - CNT_W'(1));

    always_comb begin
        edge_vec            = edge_raw;
        edge_vec[N_SRC-1]   = edge_raw[N_SRC-1] & presc_pass;
    end

    // Counter restarts whenever the prescale setting is changed
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            presc_cnt <= '0;
            presc_d   <= '0;
        end else begin
            presc_d <= prescale_in;
            if (prescale_in != presc_d)
                presc_cnt <= '0;
            else if (edge_raw[N_SRC-1])
                presc_cnt <= presc_pass ? '0 : presc_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_prescale;
    assign unused_prescale = ^prescale_in;
    assign edge_vec        = edge_raw;
`endif

    assign qbusy = (|(busy_in & ~busy_mask_in)) & ~busy_ignore_in;
    assign fire  = (|edge_vec) & trg_enb_in;
    // The last CHK/DEAD clock already counts as ready so the re-arm interval is pulse+chk+dead
    assign ready = (state == IDLE) ||
                   ((state == DEAD) && (tmr == '0)) ||
                   ((state == CHK) && (tmr == '0) && (trg_dead_time_in == '0));
    assign accept       = fire & ready & ~qbusy;
    assign lost         = fire & ~accept;
    assign daq_busy_out = (state != IDLE) | qbusy;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) src_d <= '0;
        else        src_d <= trg_src_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            eff_trg_cnt_out  <= '0;
            lost_trg_cnt_out <= '0;
        end else if (cnt_clr_in) begin
            eff_trg_cnt_out  <= '0;
            lost_trg_cnt_out <= '0;
        end else begin
            if (accept) eff_trg_cnt_out  <= eff_trg_cnt_out + CNT_W'(1);
            if (lost)   lost_trg_cnt_out <= lost_trg_cnt_out + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            tmr          <= '0;
            trg_out_N    <= '1;
            chk_out      <= 1'b0;
            eff_trg_out  <= 1'b0;
            trg_type_out <= '0;
        end else begin
            eff_trg_out <= 1'b0;
            if (accept) begin
                state        <= TRG;
                tmr          <= TW'(TRG_PULSE_WIDTH - 1);
                eff_trg_out  <= 1'b1;
                trg_type_out <= edge_vec;
                trg_out_N    <= ~out_enb_in;
                chk_out      <= 1'b0;
            end else begin
                case (state)
                    TRG: begin
                        if (tmr == '0) begin
                            state     <= CHK;
                            tmr       <= TW'(CHK_PULSE_WIDTH - 1);
                            trg_out_N <= '1;
                            chk_out   <= 1'b1;
                        end else begin
                            tmr <= tmr - TW'(1);
                        end
                    end
                    CHK: begin
                        if (tmr == '0) begin
                            chk_out <= 1'b0;
                            if (trg_dead_time_in == '0) begin
                                state <= IDLE;
                            end else begin
                                state <= DEAD;
                                tmr   <= TW'(trg_dead_time_in) - TW'(1);
                            end
                        end else begin
                            tmr <= tmr - TW'(1);
                        end
                    end
                    DEAD: begin
                        if (tmr == '0) state <= IDLE;
                        else           tmr   <= tmr - TW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/trg_out_ctrl_gen.md
Name: trg_out_ctrl_gen

Overview:
- Parametrised trigger-output controller. It merges N_SRC synchronous trigger sources into accepted triggers, qualified by enable, busy and dead time.
- Each accepted trigger drives an N_OUT-wide active-low trigger bus to the front-end electronics and a trigger-ID check strobe.
- It counts accepted and lost triggers.
- It sits between the trigger-logic and synchronisation stage and the FEE output drivers.

Parameters:
- N_SRC, 3, number of trigger sources (bit 0 = coincidence, 1 = external, 2 = cycled).
- N_BUSY, 3, number of busy inputs.
- N_OUT, 14, number of trigger output lines.
- TRG_PULSE_WIDTH, 20, trigger pulse length in clocks (≥1).
- CHK_PULSE_WIDTH, 50, check strobe length in clocks (≥1).
- DT_W, 8, dead-time register width.
- CNT_W, 16, counter width.

Ports:
- clk_in, in, 1, system clock.
- rst_in, in, 1, reset; asynchronous, active-high.
- trg_src_in, in, N_SRC, synchronous trigger sources, level.
- src_enb_in, in, N_SRC, per-source enable.
- trg_enb_in, in, 1, global trigger enable.
- busy_in, in, N_BUSY, synchronised busy flags.
- busy_mask_in, in, N_BUSY, 1 = ignore that busy.
- busy_ignore_in, in, 1, 1 = ignore all busy.
- trg_dead_time_in, in, DT_W, dead time in clocks after the check strobe.
- out_enb_in, in, N_OUT, per-output-line enable.
- prescale_in, in, CNT_W, cycled-source prescale (used only with TRG_PRESCALE_EN).
- cnt_clr_in, in, 1, synchronous clear of both counters.
- trg_out_N, out, N_OUT, active-low trigger lines.
- chk_out, out, 1, trigger-ID check strobe, active-high.
- eff_trg_out, out, 1, one-clock pulse per accepted trigger.
- trg_type_out, out, N_SRC, sources that fired on the accepted trigger.
- eff_trg_cnt_out, out, CNT_W, accepted-trigger counter.
- lost_trg_cnt_out, out, CNT_W, rejected-trigger counter.
- daq_busy_out, out, 1, high whenever the controller is not in IDLE or the qualified busy is high.

Behaviour:
- Reset:
  - trg_out_N all 1.
  - chk_out, eff_trg_out, trg_type_out and both counters 0.
  - FSM in IDLE.
  - src_d register 0.
  - Reset takes effect immediately, including mid-pulse.
- Edge detect:
  - trg_src_in is registered into src_d.
  - edge = trg_src_in & ~src_d & src_enb_in.
  - A source held high produces one edge only.
- Qualified busy:
  - qbusy = |(busy_in & ~busy_mask_in) & ~busy_ignore_in.
- FSM states: IDLE, TRG, CHK, DEAD. A down-counter is loaded on each state entry.
  - IDLE: if |edge & trg_enb_in & ~qbusy, accept:
    - next clock: eff_trg_out = 1 for one clock.
    - trg_type_out <= edge.
    - trg_out_N <= ~out_enb_in; disabled lines stay 1.
    - eff_trg_cnt_out increments.
    - go to TRG.
    - Latency: edge at clock k gives outputs asserted at k+1.
  - TRG: trg_out_N is held for exactly TRG_PULSE_WIDTH clocks, then returns to all 1. Go to CHK; chk_out = 1 for exactly CHK_PULSE_WIDTH clocks.
  - CHK: at the end, chk_out = 0. If trg_dead_time_in == 0, go to IDLE; otherwise go to DEAD for trg_dead_time_in clocks, then IDLE. trg_dead_time_in is sampled on DEAD entry.
  - A new trigger can therefore be accepted TRG_PULSE_WIDTH + CHK_PULSE_WIDTH + dead time clocks after the previous acceptance.
- Lost triggers:
  - lost_trg_cnt_out increments by 1 (not by popcount) on any clock with |edge & trg_enb_in and the trigger not accepted, i.e. FSM not in IDLE or qbusy.
  - With trg_enb_in = 0, nothing is counted.
- Simultaneous edges: one trigger; trg_type_out carries all set bits.
- Counters:
  - Wrap 2^CNT_W−1 → 0.
  - cnt_clr_in has priority over increment in the same clock.
- trg_enb_in falling mid-sequence does not truncate pulses; it only blocks new acceptance.
- out_enb_in is sampled at acceptance only.

Optional Feature:
- TRG_PRESCALE_EN defined:
  - Source bit N_SRC−1 (cycled) edges feed a prescale counter.
  - Only every prescale_in-th edge is passed to the edge vector; prescale_in of 0 or 1 passes all.
  - The counter resets on rst_in and when prescale_in changes.
  - Suppressed edges are not counted as lost.
- Not defined: prescale_in is ignored and all cycled edges pass; no prescale logic is synthesised.

Test Plan:
- Setup: N_OUT=14, TRG_PULSE_WIDTH=20, CHK_PULSE_WIDTH=50, trg_dead_time_in=3, out_enb_in=all 1, trg_enb_in=1, no busy. Single bit-0 edge → eff_trg_out one clock at k+1; trg_out_N=0 for 20 clocks; chk_out=1 for 50 clocks; next acceptance no earlier than 73 clocks after the first; eff_trg_cnt_out=1.
- Bit-0 and bit-1 edges in the same clock → one trigger, trg_type_out=3'b011, eff cnt +1, lost cnt 0.
- Second edge 30 clocks after the first → rejected, lost_trg_cnt_out=1. Edge at 80 clocks → accepted.
- busy_in[1]=1: edge lost. Set busy_mask_in[1]=1: accepted. With busy_mask_in=0 and busy_ignore_in=1: accepted.
- out_enb_in=14'h0005 → only lines 0 and 2 pulse low. Assert rst_in mid-TRG → all lines 1 and counters 0 immediately.
- With TRG_PRESCALE_EN, prescale_in=4, 8 cycled edges → 2 accepted triggers, lost cnt 0.
